// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boots, advances, stalls, redirects and halts the
// instruction index for the single-cycle core, and counts retired instructions.
module pc_sequencer #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                BOOT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              finish_flag,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc_reg,
    output logic              pc_valid,
    output logic              halted,
    output logic [1:0]        seq_state,
    output logic [31:0]       instr_count
);

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALT   = 2'd2;
    localparam logic [7:0] BOOT_INIT = 8'(BOOT_CYCLES);

    logic [1:0]        state_r,       state_s;
    logic [ADDR_W-1:0] pc_r,          pc_s;
    logic [7:0]        boot_cnt_r,    boot_cnt_s;
    logic              pend_valid_r,  pend_valid_s;
    logic [ADDR_W-1:0] pend_target_r, pend_target_s;
    logic [31:0]       instr_count_r, instr_count_s;
    logic              retire_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            sat_inc = value;
        end else begin
            sat_inc = value + 32'd1;
        end
    endfunction

    // Next-state decision for the sequencer FSM, pending redirect and retire.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        boot_cnt_s    = boot_cnt_r;
        pend_valid_s  = pend_valid_r;
        pend_target_s = pend_target_r;
        retire_s      = 1'b0;
        case (state_r)
            ST_BOOT: begin
                // A zero count is treated like one so an illegal BOOT_CYCLES cannot lock up.
                if (boot_cnt_r <= 8'd1) begin
                    state_s = ST_RUN;
                end else begin
                    boot_cnt_s = boot_cnt_r - 8'd1;
                end
            end
            ST_RUN: begin
                if (finish_flag) begin
                    state_s      = ST_HALT;
                    pend_valid_s = 1'b0;
                end else if (stall) begin
                    if (redirect_valid) begin
                        pend_valid_s  = 1'b1;
                        pend_target_s = redirect_target;
                    end else begin
                        pend_valid_s  = pend_valid_r;
                    end
                end else if (redirect_valid) begin
                    pc_s         = redirect_target;
                    pend_valid_s = 1'b0;
                    retire_s     = 1'b1;
                end else if (pend_valid_r) begin
                    pc_s         = pend_target_r;
                    pend_valid_s = 1'b0;
                    retire_s     = 1'b1;
                end else begin
                    pc_s     = pc_r + ADDR_W'(1);
                    retire_s = 1'b1;
                end
            end
            ST_HALT: begin
                if (resume && !finish_flag) begin
                    state_s = ST_RUN;
                    pc_s    = pc_r + ADDR_W'(1);
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                // Corrupted encoding: reboot, but keep the retired count.
                state_s       = ST_BOOT;
                pc_s          = RESET_PC;
                boot_cnt_s    = BOOT_INIT;
                pend_valid_s  = 1'b0;
                pend_target_s = '0;
            end
        endcase
        if (retire_s) begin
            instr_count_s = sat_inc(instr_count_r);
        end else begin
            instr_count_s = instr_count_r;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_BOOT;
            pc_r          <= RESET_PC;
            boot_cnt_r    <= BOOT_INIT;
            pend_valid_r  <= 1'b0;
            pend_target_r <= '0;
            instr_count_r <= 32'd0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            boot_cnt_r    <= boot_cnt_s;
            pend_valid_r  <= pend_valid_s;
            pend_target_r <= pend_target_s;
            instr_count_r <= instr_count_s;
        end
    end

    assign pc_reg      = pc_r;
    assign seq_state   = state_r;
    assign pc_valid    = (state_r == ST_RUN);
    assign halted      = (state_r == ST_HALT);
    assign instr_count = instr_count_r;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-cycle RISC-V core. It owns the instruction-index register and decides each cycle whether the PC boots, advances, holds, jumps, or halts. It sits between the decode/execute stage, which supplies stall, redirect and finish requests, and the instruction memory address port. The PC is a word index: sequential advance is +1.

## Interface
- `ADDR_W`, default 32: PC width in bits.
- `RESET_PC`, default 0: first instruction index fetched after boot.
- `BOOT_CYCLES`, default 2: idle cycles after reset before fetching. Legal range 1..255.
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC this cycle (memory/hazard wait).
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_target`  in  ADDR_W  next instruction index when redirect_valid.
- `finish_flag`  in  1  halt request (program end / ecall-finish).
- `resume`  in  1  leave HALT and continue.
- `pc_reg`  out  ADDR_W  current instruction index.
- `pc_valid`  out  1  pc_reg is a fetch address to be executed.
- `halted`  out  1  sequencer is in HALT.
- `seq_state`  out  2  BOOT=0, RUN=1, HALT=2 (3 unused).
- `instr_count`  out  32  retired-instruction count, saturating.

## Operation
- Reset (sampled at rising edge): pc_reg=RESET_PC, seq_state=BOOT, boot counter=BOOT_CYCLES, pending redirect cleared, instr_count=0, pc_valid=0, halted=0. Reset overrides every other input.
- BOOT: pc_valid=0. The counter decrements each edge. On the edge where the counter is 1, the block enters RUN; pc_reg stays RESET_PC. All other inputs are ignored.
- RUN: pc_valid=1. Per-edge priority, highest first:
  1. finish_flag: go to HALT, pc_reg holds, pending redirect cleared, no retire.
  2. stall: pc_reg holds, no retire. If redirect_valid, capture redirect_target into the pending register. Last capture wins.
  3. redirect_valid: pc_reg<=redirect_target, pending cleared, retire.
  4. pending redirect set: pc_reg<=pending target, pending cleared, retire.
  5. otherwise: pc_reg<=pc_reg+1, retire.
- Retire: instr_count+1, saturating at 32'hFFFFFFFF.
- Wrap: pc_reg all-ones +1 gives 0, with no flag.
- HALT: pc_valid=0, halted=1, pc_reg frozen. Redirect and stall are ignored. When resume=1 (and finish_flag=0), the block goes to RUN on that edge with pc_reg<=pc_reg+1. If resume and finish_flag are both 1, it stays in HALT.
- Unused seq_state encoding 3: the next edge forces BOOT, using the same actions as reset apart from instr_count, which is kept.

## Timing
- All outputs are registered. pc_valid, halted and seq_state are direct decodes of the state register.
- Latency reset→first valid fetch is BOOT_CYCLES edges after the edge where reset is deasserted. With BOOT_CYCLES=2, pc_valid rises 2 edges after the first edge with reset=0.
- Redirect: 1 cycle, with the target visible on pc_reg the edge after it is sampled. There are no delay slots.
- Stalled redirect: the target appears on the edge after the first cycle with stall=0, replacing the +1.
- finish_flag: halted=1 the edge after it is sampled. The instruction at the frozen pc_reg is not retired.
- Reset asserted mid-RUN or in HALT: the state is BOOT on that same edge, and any in-flight pending redirect is lost.

## Test plan
- Boot: RESET_PC=0, BOOT_CYCLES=2, reset 1 cycle, then run 5 cycles idle → pc_valid low 2 cycles, then pc_reg 0,1,2,3 with instr_count 0→3.
- Redirect: at pc_reg=5, redirect_valid=1 with target=0x40 → next pc_reg=0x40, then 0x41. instr_count increments on both edges.
- Stall+redirect: at pc_reg=8, stall=1 for 3 cycles with redirect to 0x20 on stall cycle 2 → pc_reg holds 8 for 3 edges, then 0x20, then 0x21.
- Halt/resume: finish_flag at pc_reg=0x10 together with redirect_valid → halted=1, pc_reg=0x10 frozen, and the redirect is dropped. resume after 4 cycles → pc_reg=0x11, pc_valid=1.
- Wrap and saturation: ADDR_W=4, run from pc_reg=0xF → next 0x0. Force instr_count to all-ones, then retire → count stays at all-ones.
- Reset mid-operation: reset during a stall with a pending redirect → seq_state=BOOT, pc_reg=RESET_PC, instr_count=0. After boot, pc_reg=RESET_PC and the pending target is never applied.
